// File: rtl/data_mem_dump_reader_pkg.sv
// Constants and FSM encoding shared by the data memory dump reader files.
package data_mem_dump_reader_pkg;

  localparam int NB_BYTE        = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int NB_BYTE_IDX    = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_LATCH   = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_TX = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/data_mem_dump_reader_if.sv
// Bundles the dump control, data memory debug read port and UART TX handshake.
interface data_mem_dump_reader_if #(
  parameter int NB_ADDR = 32,
  parameter int NB_DATA = 32
);
  import data_mem_dump_reader_pkg::*;

  logic               start;
  logic               busy;
  logic               done;
  logic               mem_rd_en;
  logic [NB_ADDR-1:0] mem_addr;
  logic [NB_DATA-1:0] mem_data;
  logic [NB_BYTE-1:0] tx_data;
  logic               tx_start;
  logic               tx_done;

  modport master (
    input  start, mem_data, tx_done,
    output busy, done, mem_rd_en, mem_addr, tx_data, tx_start
  );

  modport slave (
    output start, mem_data, tx_done,
    input  busy, done, mem_rd_en, mem_addr, tx_data, tx_start
  );

endinterface

// File: rtl/data_mem_dump_reader_word_serializer.sv
// Holds one memory word and presents it a byte at a time, most significant byte first.
module data_mem_dump_reader_word_serializer
  import data_mem_dump_reader_pkg::*;
#(
  parameter int NB_WORD = NB_BYTE * BYTES_PER_WORD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               load,
  input  logic               shift,
  input  logic [NB_WORD-1:0] word,
  output logic [NB_BYTE-1:0] cur_byte,
  output logic               last_byte
);

  logic [NB_WORD-1:0]     shreg;
  logic [NB_BYTE_IDX-1:0] byte_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      byte_idx <= '0;
    end else if (load) begin
      shreg    <= word;
      byte_idx <= '0;
    end else if (shift) begin
      shreg    <= shreg << NB_BYTE;
      byte_idx <= byte_idx + 1'b1;
    end else if (clear) begin
      byte_idx <= '0;
    end
  end

  assign cur_byte  = shreg[NB_WORD-1 -: NB_BYTE];
  assign last_byte = (byte_idx == NB_BYTE_IDX'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/data_mem_dump_reader.sv
// Walks the data memory word by word and streams every byte to the debug UART TX.
module data_mem_dump_reader
  import data_mem_dump_reader_pkg::*;
#(
  parameter int NB_ADDR   = 32,
  parameter int NB_DATA   = 32,
  parameter int MEM_DEPTH = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  data_mem_dump_reader_if.master bus
);

  // One spare bit so the index can never wrap before the last-word compare.
  localparam int NB_WIDX = $clog2(MEM_DEPTH) + 1;

  state_t               state;
  state_t               state_next;
  logic [NB_WIDX-1:0]   word_idx;
  logic                 word_clear;
  logic                 word_inc;
  logic                 last_word;
  logic                 ser_clear;
  logic                 ser_load;
  logic                 ser_shift;
  logic                 last_byte;
  logic [NB_BYTE-1:0]   cur_byte;

  data_mem_dump_reader_word_serializer #(
    .NB_WORD (NB_DATA)
  ) u_serializer (
    .clk       (i_clock),
    .rst       (i_reset),
    .clear     (ser_clear),
    .load      (ser_load),
    .shift     (ser_shift),
    .word      (bus.mem_data),
    .cur_byte  (cur_byte),
    .last_byte (last_byte)
  );

  assign last_word = (word_idx == NB_WIDX'(MEM_DEPTH - 1));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      word_idx <= '0;
    end else if (word_clear) begin
      word_idx <= '0;
    end else if (word_inc) begin
      word_idx <= word_idx + 1'b1;
    end
  end

  always_comb begin
    state_next    = state;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;
    bus.mem_rd_en = 1'b0;
    bus.mem_addr  = '0;
    bus.tx_data   = '0;
    bus.tx_start  = 1'b0;
    word_clear    = 1'b0;
    word_inc      = 1'b0;
    ser_clear     = 1'b0;
    ser_load      = 1'b0;
    ser_shift     = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          word_clear = 1'b1;
          ser_clear  = 1'b1;
          state_next = ST_READ;
        end
      end
      ST_READ: begin
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = NB_ADDR'({word_idx, NB_BYTE_IDX'(0)});
        state_next    = ST_LATCH;
      end
      ST_LATCH: begin
        ser_load   = 1'b1;
        state_next = ST_SEND;
      end
      ST_SEND: begin
        bus.tx_start = 1'b1;
        bus.tx_data  = cur_byte;
        state_next   = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        bus.tx_data = cur_byte;
        if (bus.tx_done) begin
          if (!last_byte) begin
            ser_shift  = 1'b1;
            state_next = ST_SEND;
          end else if (!last_word) begin
            word_inc   = 1'b1;
            ser_clear  = 1'b1;
            state_next = ST_READ;
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        bus.done   = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_data_mem_dump_reader.sv
// Self-checking bench: a two-word reader with a slow TX and a one-word reader with an immediate TX.
module tb_data_mem_dump_reader;
  import data_mem_dump_reader_pkg::*;

  localparam int DEPTH_A = 2;
  localparam int DEPTH_B = 1;

  logic clk;
  logic rst;
  int   assertions = 0;
  int   failures   = 0;

  data_mem_dump_reader_if #(.NB_ADDR(32), .NB_DATA(32)) bus_a ();
  data_mem_dump_reader_if #(.NB_ADDR(32), .NB_DATA(32)) bus_b ();

  data_mem_dump_reader #(.NB_ADDR(32), .NB_DATA(32), .MEM_DEPTH(DEPTH_A)) dut_a (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus_a.master)
  );

  data_mem_dump_reader #(.NB_ADDR(32), .NB_DATA(32), .MEM_DEPTH(DEPTH_B)) dut_b (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus_b.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name, input int budget);
    assertions++;
    failures++;
    $display("[TB] FAIL %s: event not seen within %0d cycles, required it", name, budget);
  endtask

  // Synchronous-read memories: a requested word is visible only during the following cycle.
  logic [31:0] mem_a [DEPTH_A];
  logic        rd_pend_a, rd_pend_b;
  logic [31:0] rd_addr_a, rd_addr_b;

  initial begin
    mem_a[0] = 32'h01020304;
    mem_a[1] = 32'h000000FF;
    bus_a.mem_data = 32'hA5A5A5A5;
    forever begin
      @(negedge clk);
      rd_pend_a = bus_a.mem_rd_en;
      rd_addr_a = bus_a.mem_addr;
      @(posedge clk);
      #1;
      if (rd_pend_a && (rd_addr_a >> 2) < 32'(DEPTH_A)) bus_a.mem_data = mem_a[int'(rd_addr_a >> 2)];
      else bus_a.mem_data = 32'hA5A5A5A5;
    end
  end

  initial begin
    bus_b.mem_data = 32'h5A5A5A5A;
    forever begin
      @(negedge clk);
      rd_pend_b = bus_b.mem_rd_en;
      rd_addr_b = bus_b.mem_addr;
      @(posedge clk);
      #1;
      bus_b.mem_data = (rd_pend_b && rd_addr_b == 32'd0) ? 32'hDEADBEEF : 32'h5A5A5A5A;
    end
  end

  // TX models answer tx_start with a one-cycle tx_done, tx_lat cycles later.
  int   tx_lat_a = 3;
  logic tx_done_model_a, tx_done_spur_a;
  assign bus_a.tx_done = tx_done_model_a | tx_done_spur_a;

  initial begin
    tx_done_model_a = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_a.tx_start && !rst) begin
        repeat (tx_lat_a) @(posedge clk);
        #1 tx_done_model_a = 1'b1;
        @(posedge clk);
        #1 tx_done_model_a = 1'b0;
      end
    end
  end

  initial begin
    bus_b.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_b.tx_start && !rst) begin
        @(posedge clk);
        #1 bus_b.tx_done = 1'b1;
        @(posedge clk);
        #1 bus_b.tx_done = 1'b0;
      end
    end
  end

  // Reference model for reader A: expected address/byte streams and the cycle each event is due.
  int          cyc = 0;
  int          exp_rd_cyc = -1, exp_tx_cyc = -1, exp_done_cyc = -1;
  bit          active = 1'b0, awaiting = 1'b0;
  int          sent = 0;
  logic [7:0]  last_sent = 8'h00;
  logic [31:0] exp_w;
  logic [7:0]  exp_bytes[$];
  logic [31:0] exp_addrs[$];
  logic [7:0]  log_bytes_a[$];
  logic [31:0] log_addrs_a[$];
  int          done_cnt_a = 0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        active = 1'b0;
        awaiting = 1'b0;
        exp_bytes.delete();
        exp_addrs.delete();
        exp_rd_cyc = -1;
        exp_tx_cyc = -1;
        exp_done_cyc = -1;
      end else begin
        checkOutput("busy_a", 32'(bus_a.busy), 32'(active));
        checkOutput("rd_en_a", 32'(bus_a.mem_rd_en), 32'(cyc == exp_rd_cyc));
        checkOutput("tx_start_a", 32'(bus_a.tx_start), 32'(cyc == exp_tx_cyc));
        checkOutput("done_a", 32'(bus_a.done), 32'(cyc == exp_done_cyc));
        if (bus_a.mem_rd_en) begin
          log_addrs_a.push_back(bus_a.mem_addr);
          exp_w = 32'hFFFFFFFF;
          if (exp_addrs.size() > 0) exp_w = exp_addrs.pop_front();
          checkOutput("addr_a", bus_a.mem_addr, exp_w);
        end
        if (bus_a.tx_start) begin
          log_bytes_a.push_back(bus_a.tx_data);
          exp_w = 32'h1FF;
          if (exp_bytes.size() > 0) exp_w = 32'(exp_bytes.pop_front());
          checkOutput("tx_data_a", 32'(bus_a.tx_data), exp_w);
          last_sent = exp_w[7:0];
          awaiting = 1'b1;
          sent++;
        end else if (awaiting) begin
          checkOutput("tx_hold_a", 32'(bus_a.tx_data), 32'(last_sent));
          if (bus_a.tx_done) begin
            awaiting = 1'b0;
            if (sent % 4 != 0) begin
              exp_tx_cyc = cyc + 1;
            end else if (exp_bytes.size() > 0) begin
              exp_rd_cyc = cyc + 1;
              exp_tx_cyc = cyc + 3;
            end else begin
              exp_done_cyc = cyc + 1;
            end
          end
        end
        if (bus_a.done) begin
          done_cnt_a++;
          checkOutput("dump_complete_a", 32'(exp_bytes.size() + exp_addrs.size()), 32'd0);
          active = 1'b0;
        end else if (!active && bus_a.start) begin
          active = 1'b1;
          sent = 0;
          for (int w = 0; w < DEPTH_A; w++) begin
            exp_addrs.push_back(32'(w * 4));
            for (int b = 3; b >= 0; b--) exp_bytes.push_back(mem_a[w][b*8 +: 8]);
          end
          exp_rd_cyc = cyc + 1;
          exp_tx_cyc = cyc + 3;
        end
      end
    end
  end

  task automatic applyStimulus(input int cycles);
    @(posedge clk);
    #1 bus_a.start = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 bus_a.start = 1'b0;
  endtask

  task automatic waitDoneA(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (bus_a.done) return;
    end
    timeoutFail("done_a", budget);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"},     32'(bus_a.busy), 32'd0);
    checkOutput({tag, "_done"},     32'(bus_a.done), 32'd0);
    checkOutput({tag, "_rd_en"},    32'(bus_a.mem_rd_en), 32'd0);
    checkOutput({tag, "_addr"},     bus_a.mem_addr, 32'd0);
    checkOutput({tag, "_tx_data"},  32'(bus_a.tx_data), 32'd0);
    checkOutput({tag, "_tx_start"}, 32'(bus_a.tx_start), 32'd0);
  endtask

  // Hand-computed stream for memory {0x01020304, 0x000000FF}.
  task automatic checkDumpA(input string tag, input int mb, input int ma);
    logic [7:0]  want_b [8];
    logic [31:0] want_a [2];
    want_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'hFF};
    want_a = '{32'd0, 32'd4};
    for (int i = 0; i < 2; i++)
      checkOutput($sformatf("%s_addr%0d", tag, i),
                  (ma + i < log_addrs_a.size()) ? log_addrs_a[ma + i] : 32'hFFFFFFFF, want_a[i]);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("%s_byte%0d", tag, i),
                  (mb + i < log_bytes_a.size()) ? 32'(log_bytes_a[mb + i]) : 32'h1FF, 32'(want_b[i]));
  endtask

  task automatic testZeroLatencyB();
    int         done_at = -1;
    int         first_tx_at = -1;
    int         rd_at = -1;
    int         dones = 0;
    logic [31:0] rd_addr = 32'hFFFFFFFF;
    logic       busy_after = 1'b1;
    logic [7:0] got[$];
    logic [7:0] want [4];
    want = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    @(posedge clk);
    #1 bus_b.start = 1'b1;
    @(posedge clk);
    #1 bus_b.start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (bus_b.mem_rd_en && rd_at < 0) begin
        rd_at = k;
        rd_addr = bus_b.mem_addr;
      end
      if (bus_b.tx_start) begin
        if (first_tx_at < 0) first_tx_at = k;
        got.push_back(bus_b.tx_data);
      end
      if (bus_b.done) begin
        dones++;
        done_at = k;
      end
      if (k == 12) busy_after = bus_b.busy;
    end
    checkOutput("b_rd_cycle", 32'(rd_at), 32'd1);
    checkOutput("b_rd_addr", rd_addr, 32'd0);
    checkOutput("b_first_tx_cycle", 32'(first_tx_at), 32'd3);
    checkOutput("b_byte_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("b_byte%0d", i), (i < got.size()) ? 32'(got[i]) : 32'h1FF, 32'(want[i]));
    checkOutput("b_done_cycle", 32'(done_at), 32'd11);
    checkOutput("b_done_count", 32'(dones), 32'd1);
    checkOutput("b_busy_after_done", 32'(busy_after), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  int  mb, ma, md, n;
  bit  found;

  initial begin
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    tx_done_spur_a = 1'b0;
    rst = 1'b1;
    #12;
    checkIdleOutputs("reset");
    checkOutput("reset_busy_b", 32'(bus_b.busy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] two-word dump, TX latency 3");
    mb = log_bytes_a.size(); ma = log_addrs_a.size(); md = done_cnt_a;
    applyStimulus(1);
    waitDoneA(200);
    repeat (3) @(posedge clk);
    #1;
    checkDumpA("dump1", mb, ma);
    checkOutput("dump1_byte_count", 32'(log_bytes_a.size() - mb), 32'd8);
    checkOutput("dump1_done_count", 32'(done_cnt_a - md), 32'd1);

    $display("[TB] one-word dump, immediate TX");
    testZeroLatencyB();

    $display("[TB] start during SEND/WAIT_TX, stray tx_done during READ");
    mb = log_bytes_a.size(); ma = log_addrs_a.size(); md = done_cnt_a;
    applyStimulus(1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      if (bus_a.tx_start) found = 1'b1;
    end
    if (!found) timeoutFail("first_send_a", 20);
    bus_a.start = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 bus_a.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk);
      #1;
      if (bus_a.mem_rd_en && bus_a.mem_addr == 32'd4) begin
        found = 1'b1;
        tx_done_spur_a = 1'b1;
        @(posedge clk);
        #1 tx_done_spur_a = 1'b0;
      end
    end
    if (!found) timeoutFail("second_read_a", 60);
    waitDoneA(200);
    repeat (3) @(posedge clk);
    #1;
    checkDumpA("spurious", mb, ma);
    checkOutput("spurious_done_count", 32'(done_cnt_a - md), 32'd1);

    $display("[TB] reset during second byte of word 1");
    md = done_cnt_a;
    applyStimulus(1);
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk);
      #1;
      if (bus_a.tx_start) n++;
      if (n == 6) found = 1'b1;
    end
    if (!found) timeoutFail("sixth_send_a", 100);
    #2 rst = 1'b1;
    #1 checkIdleOutputs("midreset");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("midreset_no_done", 32'(done_cnt_a - md), 32'd0);
    mb = log_bytes_a.size(); ma = log_addrs_a.size(); md = done_cnt_a;
    applyStimulus(1);
    waitDoneA(200);
    repeat (3) @(posedge clk);
    #1;
    checkDumpA("restart", mb, ma);
    checkOutput("restart_done_count", 32'(done_cnt_a - md), 32'd1);

    $display("[TB] start held high across DONE");
    mb = log_bytes_a.size(); ma = log_addrs_a.size(); md = done_cnt_a;
    @(posedge clk);
    #1 bus_a.start = 1'b1;
    waitDoneA(200);
    @(posedge clk);
    #1 checkOutput("held_idle_busy", 32'(bus_a.busy), 32'd0);
    @(posedge clk);
    #1 checkOutput("held_restart_rd_en", 32'(bus_a.mem_rd_en), 32'd1);
    bus_a.start = 1'b0;
    waitDoneA(200);
    repeat (3) @(posedge clk);
    #1;
    checkDumpA("held_first", mb, ma);
    checkDumpA("held_second", mb + 8, ma + 2);
    checkOutput("held_byte_count", 32'(log_bytes_a.size() - mb), 32'd16);
    checkOutput("held_done_count", 32'(done_cnt_a - md), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
